// File: rtl/wb_stage_buf_if.sv
// Bus bundle for the write-back retire buffer: MEM handshake and payload,
// GPR/CP0 commit ports, bypass query and the retire trace port.
interface wb_stage_buf_if #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2,
  parameter int REG_AW = 5
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              ms_to_ws_valid;
  logic              ws_allowin;
  logic [DATA_W-1:0] ms_pc;
  logic [DATA_W-1:0] ms_result;
  logic [DATA_W-1:0] ms_rt_value;
  logic [DATA_W-1:0] ms_badvaddr;
  logic [REG_AW-1:0] ms_dest;
  logic [REG_AW-1:0] ms_cp0_addr;
  logic              ms_gr_we;
  logic              ms_res_from_cp0;
  logic              ms_mtc0_we;
  logic              ms_ex;
  logic              ms_bd;
  logic              ms_eret;
  logic [4:0]        ms_excode;

  logic              rf_stall;
  logic [DATA_W-1:0] cp0_rdata;

  logic              rf_we;
  logic [REG_AW-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;

  logic              ws_ex;
  logic              ws_bd;
  logic              ws_eret;
  logic              mtc0_we;
  logic [4:0]        ws_excode;
  logic [DATA_W-1:0] ws_pc;
  logic [DATA_W-1:0] ws_badvaddr;
  logic [DATA_W-1:0] cp0_wdata;
  logic [REG_AW-1:0] cp0_addr;
  logic              ws_flush;

  logic [REG_AW-1:0] fwd_raddr;
  logic              fwd_hit;
  logic              fwd_pending;
  logic [DATA_W-1:0] fwd_data;

  logic [CNT_W-1:0]  ws_count;

  logic [31:0]       debug_wb_pc;
  logic [3:0]        debug_wb_rf_wen;
  logic [4:0]        debug_wb_rf_wnum;
  logic [31:0]       debug_wb_rf_wdata;

  // Buffer side
  modport slave (
    input  ms_to_ws_valid, ms_pc, ms_result, ms_rt_value, ms_badvaddr,
           ms_dest, ms_cp0_addr, ms_gr_we, ms_res_from_cp0, ms_mtc0_we,
           ms_ex, ms_bd, ms_eret, ms_excode, rf_stall, cp0_rdata, fwd_raddr,
    output ws_allowin, rf_we, rf_waddr, rf_wdata, ws_ex, ws_bd, ws_eret,
           mtc0_we, ws_excode, ws_pc, ws_badvaddr, cp0_wdata, cp0_addr,
           ws_flush, fwd_hit, fwd_pending, fwd_data, ws_count,
           debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata
  );

  // Pipeline / environment side
  modport master (
    output ms_to_ws_valid, ms_pc, ms_result, ms_rt_value, ms_badvaddr,
           ms_dest, ms_cp0_addr, ms_gr_we, ms_res_from_cp0, ms_mtc0_we,
           ms_ex, ms_bd, ms_eret, ms_excode, rf_stall, cp0_rdata, fwd_raddr,
    input  ws_allowin, rf_we, rf_waddr, rf_wdata, ws_ex, ws_bd, ws_eret,
           mtc0_we, ws_excode, ws_pc, ws_badvaddr, cp0_wdata, cp0_addr,
           ws_flush, fwd_hit, fwd_pending, fwd_data, ws_count,
           debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata
  );
endinterface

// File: rtl/wb_stage_buf.sv
// Write-back retire buffer: in-order circular FIFO of MEM results that commits
// one head entry per cycle to the GPR/CP0 ports and serves register bypass.
module wb_stage_buf #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2,
  parameter int REG_AW = 5
) (
  input  logic          clk,
  input  logic          resetn,
  wb_stage_buf_if.slave wb
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] result;
    logic [DATA_W-1:0] rt_value;
    logic [DATA_W-1:0] badvaddr;
    logic [REG_AW-1:0] dest;
    logic [REG_AW-1:0] cp0_addr;
    logic              gr_we;
    logic              res_from_cp0;
    logic              mtc0_we;
    logic              ex;
    logic              bd;
    logic              eret;
    logic [4:0]        excode;
  } entry_t;

  entry_t           entry_q [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  entry_t           in_entry;
  entry_t           hd;
  logic             nonempty;
  logic             commit;
  logic             allowin;
  logic             push;
  logic             ex_commit;
  logic             eret_commit;
  logic             flush;
  logic [DATA_W-1:0] rf_wdata_raw;
  logic [PTR_W-1:0] fwd_idx;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    in_entry              = '0;
    in_entry.pc           = wb.ms_pc;
    in_entry.result       = wb.ms_result;
    in_entry.rt_value     = wb.ms_rt_value;
    in_entry.badvaddr     = wb.ms_badvaddr;
    in_entry.dest         = wb.ms_dest;
    in_entry.cp0_addr     = wb.ms_cp0_addr;
    in_entry.gr_we        = wb.ms_gr_we;
    in_entry.res_from_cp0 = wb.ms_res_from_cp0;
    in_entry.mtc0_we      = wb.ms_mtc0_we;
    in_entry.ex           = wb.ms_ex;
    in_entry.bd           = wb.ms_bd;
    in_entry.eret         = wb.ms_eret;
    in_entry.excode       = wb.ms_excode;
  end

  assign hd          = entry_q[head_q];
  assign nonempty    = (count_q != '0);
  assign commit      = nonempty && !wb.rf_stall;
  // A committing head frees its slot in the same cycle, so a full buffer still accepts
  assign allowin     = (count_q < CNT_W'(DEPTH)) || commit;
  assign push        = wb.ms_to_ws_valid && allowin;
  assign ex_commit   = commit && hd.ex;
  assign eret_commit = commit && hd.eret && !hd.ex;
  assign flush       = ex_commit || eret_commit;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    valid_d = valid_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      valid_d = '0;
    end else begin
      if (commit) begin
        valid_d[head_q] = 1'b0;
        head_d          = ptr_inc(head_q);
      end
      if (push) begin
        valid_d[tail_q] = 1'b1;
        tail_d          = ptr_inc(tail_q);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(commit);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

  // Payload storage carries no reset; valid bits alone qualify it
  always_ff @(posedge clk) begin
    if (resetn && push && !flush) begin
      entry_q[tail_q] <= in_entry;
    end
  end

  // Walk oldest to youngest so the last match, the youngest producer, wins
  always_comb begin
    wb.fwd_hit     = 1'b0;
    wb.fwd_pending = 1'b0;
    wb.fwd_data    = '0;
    fwd_idx        = head_q;
    for (int i = 0; i < DEPTH; i++) begin
      fwd_idx = head_q + PTR_W'(i);
      if (valid_q[fwd_idx] && entry_q[fwd_idx].gr_we && !entry_q[fwd_idx].ex &&
          (entry_q[fwd_idx].dest == wb.fwd_raddr) && (wb.fwd_raddr != '0)) begin
        wb.fwd_hit     = 1'b1;
        wb.fwd_pending = entry_q[fwd_idx].res_from_cp0;
        wb.fwd_data    = entry_q[fwd_idx].result;
      end
    end
  end

  assign rf_wdata_raw = hd.res_from_cp0 ? wb.cp0_rdata : hd.result;

  assign wb.ws_allowin  = allowin;
  assign wb.ws_count    = count_q;

  assign wb.rf_we       = commit && hd.gr_we && !hd.ex;
  assign wb.rf_waddr    = nonempty ? hd.dest : '0;
  assign wb.rf_wdata    = nonempty ? rf_wdata_raw : '0;

  assign wb.cp0_addr    = nonempty ? hd.cp0_addr : '0;
  assign wb.mtc0_we     = commit && hd.mtc0_we && !hd.ex;
  assign wb.cp0_wdata   = nonempty ? hd.rt_value : '0;

  assign wb.ws_ex       = ex_commit;
  assign wb.ws_eret     = eret_commit;
  assign wb.ws_flush    = flush;
  assign wb.ws_excode   = nonempty ? hd.excode : '0;
  assign wb.ws_badvaddr = nonempty ? hd.badvaddr : '0;
  assign wb.ws_bd       = nonempty && hd.bd;
  assign wb.ws_pc       = nonempty ? hd.pc : '0;

  assign wb.debug_wb_pc       = nonempty ? 32'(hd.pc) : 32'h0;
  assign wb.debug_wb_rf_wen   = {4{wb.rf_we}};
  assign wb.debug_wb_rf_wnum  = 5'(wb.rf_waddr);
  assign wb.debug_wb_rf_wdata = 32'(wb.rf_wdata);
endmodule

// File: tb/tb_wb_stage_buf.sv
// Directed bench for wb_stage_buf: reset, single commit, full/stall, bypass,
// exception and eret flush, CP0 read/write and mid-run reset.
module tb_wb_stage_buf;
  logic clk;
  logic resetn;
  int   total;
  int   bad;

  wb_stage_buf_if #(.DATA_W(32), .DEPTH(2), .REG_AW(5)) bus ();

  wb_stage_buf #(.DATA_W(32), .DEPTH(2), .REG_AW(5)) dut (
    .clk   (clk),
    .resetn(resetn),
    .wb    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Inputs change and outputs are sampled in the low phase of the clock
  task automatic step();
    @(negedge clk);
  endtask

  task automatic set_ms(input logic v, input logic [4:0] dest,
                        input logic [31:0] result, input logic gr_we);
    bus.ms_to_ws_valid  = v;
    bus.ms_dest         = dest;
    bus.ms_result       = result;
    bus.ms_gr_we        = gr_we;
    bus.ms_pc           = 32'h1000_0000 | result;
    bus.ms_rt_value     = 32'h0;
    bus.ms_badvaddr     = 32'h0;
    bus.ms_cp0_addr     = 5'd0;
    bus.ms_res_from_cp0 = 1'b0;
    bus.ms_mtc0_we      = 1'b0;
    bus.ms_ex           = 1'b0;
    bus.ms_bd           = 1'b0;
    bus.ms_eret         = 1'b0;
    bus.ms_excode       = 5'd0;
  endtask

  task automatic test_reset();
    resetn        = 1'b0;
    bus.rf_stall  = 1'b0;
    bus.cp0_rdata = 32'h0;
    bus.fwd_raddr = 5'd3;
    set_ms(1'b0, 5'd0, 32'h0, 1'b0);
    repeat (3) step();
    #1;
    total++; if (bus.ws_count !== 2'd0) begin bad++; $display("[TB] FAIL reset_count: got %0d expected 0", bus.ws_count); end
    total++; if (bus.ws_allowin !== 1'b1) begin bad++; $display("[TB] FAIL reset_allowin: got %0b expected 1", bus.ws_allowin); end
    total++; if (bus.rf_we !== 1'b0) begin bad++; $display("[TB] FAIL reset_rf_we: got %0b expected 0", bus.rf_we); end
    total++; if (bus.ws_flush !== 1'b0) begin bad++; $display("[TB] FAIL reset_flush: got %0b expected 0", bus.ws_flush); end
    total++; if (bus.fwd_hit !== 1'b0) begin bad++; $display("[TB] FAIL reset_fwd_hit: got %0b expected 0", bus.fwd_hit); end
    resetn = 1'b1;
    step();
    #1;
    total++; if (bus.ws_count !== 2'd0) begin bad++; $display("[TB] FAIL post_reset_count: got %0d expected 0", bus.ws_count); end
    total++; if (bus.mtc0_we !== 1'b0) begin bad++; $display("[TB] FAIL post_reset_mtc0: got %0b expected 0", bus.mtc0_we); end
  endtask

  task automatic test_basic_commit();
    step();
    set_ms(1'b1, 5'd3, 32'h1234, 1'b1);
    #1;
    total++; if (bus.ws_allowin !== 1'b1) begin bad++; $display("[TB] FAIL basic_allowin: got %0b expected 1", bus.ws_allowin); end
    step();
    set_ms(1'b0, 5'd0, 32'h0, 1'b0);
    #1;
    total++; if (bus.ws_count !== 2'd1) begin bad++; $display("[TB] FAIL basic_count1: got %0d expected 1", bus.ws_count); end
    total++; if (bus.rf_we !== 1'b1) begin bad++; $display("[TB] FAIL basic_rf_we: got %0b expected 1", bus.rf_we); end
    total++; if (bus.rf_waddr !== 5'd3) begin bad++; $display("[TB] FAIL basic_waddr: got %0d expected 3", bus.rf_waddr); end
    total++; if (bus.rf_wdata !== 32'h1234) begin bad++; $display("[TB] FAIL basic_wdata: got %h expected 00001234", bus.rf_wdata); end
    total++; if (bus.debug_wb_rf_wen !== 4'hf) begin bad++; $display("[TB] FAIL basic_dbg_wen: got %h expected f", bus.debug_wb_rf_wen); end
    total++; if (bus.debug_wb_pc !== 32'h1000_1234) begin bad++; $display("[TB] FAIL basic_dbg_pc: got %h expected 10001234", bus.debug_wb_pc); end
    step();
    #1;
    total++; if (bus.ws_count !== 2'd0) begin bad++; $display("[TB] FAIL basic_count0: got %0d expected 0", bus.ws_count); end
    total++; if (bus.rf_waddr !== 5'd0) begin bad++; $display("[TB] FAIL basic_idle_waddr: got %0d expected 0", bus.rf_waddr); end
  endtask

  task automatic test_full_stall();
    bus.rf_stall = 1'b1;
    set_ms(1'b1, 5'd1, 32'hA1, 1'b1);
    step();
    set_ms(1'b1, 5'd2, 32'hB2, 1'b1);
    step();
    set_ms(1'b1, 5'd3, 32'hC3, 1'b1);
    #1;
    total++; if (bus.ws_count !== 2'd2) begin bad++; $display("[TB] FAIL full_count: got %0d expected 2", bus.ws_count); end
    total++; if (bus.ws_allowin !== 1'b0) begin bad++; $display("[TB] FAIL full_allowin: got %0b expected 0", bus.ws_allowin); end
    total++; if (bus.rf_we !== 1'b0) begin bad++; $display("[TB] FAIL full_stall_we: got %0b expected 0", bus.rf_we); end
    step();
    bus.rf_stall = 1'b0;
    #1;
    total++; if (bus.ws_allowin !== 1'b1) begin bad++; $display("[TB] FAIL full_commit_allowin: got %0b expected 1", bus.ws_allowin); end
    total++; if (bus.rf_wdata !== 32'hA1) begin bad++; $display("[TB] FAIL full_order_a: got %h expected 000000a1", bus.rf_wdata); end
    total++; if (bus.rf_waddr !== 5'd1) begin bad++; $display("[TB] FAIL full_waddr_a: got %0d expected 1", bus.rf_waddr); end
    step();
    set_ms(1'b0, 5'd0, 32'h0, 1'b0);
    #1;
    total++; if (bus.ws_count !== 2'd2) begin bad++; $display("[TB] FAIL full_push_commit_count: got %0d expected 2", bus.ws_count); end
    total++; if (bus.rf_wdata !== 32'hB2) begin bad++; $display("[TB] FAIL full_order_b: got %h expected 000000b2", bus.rf_wdata); end
    step();
    #1;
    total++; if (bus.rf_wdata !== 32'hC3) begin bad++; $display("[TB] FAIL full_order_c: got %h expected 000000c3", bus.rf_wdata); end
    total++; if (bus.ws_count !== 2'd1) begin bad++; $display("[TB] FAIL full_count_c: got %0d expected 1", bus.ws_count); end
    step();
    #1;
    total++; if (bus.ws_count !== 2'd0) begin bad++; $display("[TB] FAIL full_drained: got %0d expected 0", bus.ws_count); end
  endtask

  task automatic test_bypass();
    bus.rf_stall = 1'b1;
    set_ms(1'b1, 5'd5, 32'h11, 1'b1);
    step();
    set_ms(1'b1, 5'd5, 32'h22, 1'b1);
    step();
    set_ms(1'b0, 5'd0, 32'h0, 1'b0);
    bus.fwd_raddr = 5'd5;
    #1;
    total++; if (bus.fwd_hit !== 1'b1) begin bad++; $display("[TB] FAIL byp_hit: got %0b expected 1", bus.fwd_hit); end
    total++; if (bus.fwd_data !== 32'h22) begin bad++; $display("[TB] FAIL byp_youngest: got %h expected 00000022", bus.fwd_data); end
    total++; if (bus.fwd_pending !== 1'b0) begin bad++; $display("[TB] FAIL byp_pending: got %0b expected 0", bus.fwd_pending); end
    bus.fwd_raddr = 5'd0;
    #1;
    total++; if (bus.fwd_hit !== 1'b0) begin bad++; $display("[TB] FAIL byp_r0: got %0b expected 0", bus.fwd_hit); end
    bus.fwd_raddr = 5'd6;
    #1;
    total++; if (bus.fwd_hit !== 1'b0) begin bad++; $display("[TB] FAIL byp_miss: got %0b expected 0", bus.fwd_hit); end
    step();
    bus.fwd_raddr = 5'd5;
    bus.rf_stall  = 1'b0;
    step();
    #1;
    total++; if (bus.fwd_hit !== 1'b1) begin bad++; $display("[TB] FAIL byp_commit_visible: got %0b expected 1", bus.fwd_hit); end
    total++; if (bus.fwd_data !== 32'h22) begin bad++; $display("[TB] FAIL byp_commit_data: got %h expected 00000022", bus.fwd_data); end
    step();
    #1;
    total++; if (bus.fwd_hit !== 1'b0) begin bad++; $display("[TB] FAIL byp_drained: got %0b expected 0", bus.fwd_hit); end
  endtask

  task automatic test_exception_flush();
    bus.rf_stall = 1'b1;
    set_ms(1'b1, 5'd7, 32'h77, 1'b1);
    bus.ms_ex       = 1'b1;
    bus.ms_excode   = 5'h04;
    bus.ms_badvaddr = 32'hDEAD_0003;
    bus.ms_pc       = 32'hBFC0_0100;
    bus.ms_bd       = 1'b1;
    step();
    set_ms(1'b1, 5'd8, 32'h88, 1'b1);
    step();
    set_ms(1'b0, 5'd0, 32'h0, 1'b0);
    bus.fwd_raddr = 5'd7;
    #1;
    total++; if (bus.fwd_hit !== 1'b0) begin bad++; $display("[TB] FAIL ex_no_bypass: got %0b expected 0", bus.fwd_hit); end
    step();
    bus.rf_stall = 1'b0;
    set_ms(1'b1, 5'd10, 32'hAA, 1'b1);
    #1;
    total++; if (bus.ws_ex !== 1'b1) begin bad++; $display("[TB] FAIL ex_ws_ex: got %0b expected 1", bus.ws_ex); end
    total++; if (bus.ws_flush !== 1'b1) begin bad++; $display("[TB] FAIL ex_flush: got %0b expected 1", bus.ws_flush); end
    total++; if (bus.rf_we !== 1'b0) begin bad++; $display("[TB] FAIL ex_rf_we: got %0b expected 0", bus.rf_we); end
    total++; if (bus.ws_excode !== 5'h04) begin bad++; $display("[TB] FAIL ex_excode: got %h expected 04", bus.ws_excode); end
    total++; if (bus.ws_badvaddr !== 32'hDEAD_0003) begin bad++; $display("[TB] FAIL ex_badvaddr: got %h expected dead0003", bus.ws_badvaddr); end
    total++; if (bus.ws_pc !== 32'hBFC0_0100) begin bad++; $display("[TB] FAIL ex_pc: got %h expected bfc00100", bus.ws_pc); end
    total++; if (bus.ws_bd !== 1'b1) begin bad++; $display("[TB] FAIL ex_bd: got %0b expected 1", bus.ws_bd); end
    step();
    set_ms(1'b0, 5'd0, 32'h0, 1'b0);
    bus.fwd_raddr = 5'd10;
    #1;
    total++; if (bus.ws_count !== 2'd0) begin bad++; $display("[TB] FAIL ex_count_after: got %0d expected 0", bus.ws_count); end
    total++; if (bus.ws_flush !== 1'b0) begin bad++; $display("[TB] FAIL ex_flush_after: got %0b expected 0", bus.ws_flush); end
    total++; if (bus.fwd_hit !== 1'b0) begin bad++; $display("[TB] FAIL ex_push_discarded: got %0b expected 0", bus.fwd_hit); end
  endtask

  task automatic test_eret();
    bus.rf_stall = 1'b0;
    set_ms(1'b1, 5'd0, 32'h180, 1'b0);
    bus.ms_eret = 1'b1;
    step();
    set_ms(1'b0, 5'd0, 32'h0, 1'b0);
    #1;
    total++; if (bus.ws_eret !== 1'b1) begin bad++; $display("[TB] FAIL eret_pulse: got %0b expected 1", bus.ws_eret); end
    total++; if (bus.ws_flush !== 1'b1) begin bad++; $display("[TB] FAIL eret_flush: got %0b expected 1", bus.ws_flush); end
    total++; if (bus.ws_ex !== 1'b0) begin bad++; $display("[TB] FAIL eret_ex: got %0b expected 0", bus.ws_ex); end
    step();
    #1;
    total++; if (bus.ws_eret !== 1'b0) begin bad++; $display("[TB] FAIL eret_after: got %0b expected 0", bus.ws_eret); end
  endtask

  task automatic test_cp0();
    bus.rf_stall = 1'b1;
    set_ms(1'b1, 5'd9, 32'h0BAD, 1'b1);
    bus.ms_res_from_cp0 = 1'b1;
    bus.ms_cp0_addr     = 5'd12;
    step();
    set_ms(1'b0, 5'd0, 32'h0, 1'b0);
    bus.fwd_raddr = 5'd9;
    #1;
    total++; if (bus.fwd_hit !== 1'b1) begin bad++; $display("[TB] FAIL cp0_fwd_hit: got %0b expected 1", bus.fwd_hit); end
    total++; if (bus.fwd_pending !== 1'b1) begin bad++; $display("[TB] FAIL cp0_fwd_pending: got %0b expected 1", bus.fwd_pending); end
    total++; if (bus.cp0_addr !== 5'd12) begin bad++; $display("[TB] FAIL cp0_addr: got %0d expected 12", bus.cp0_addr); end
    step();
    bus.cp0_rdata = 32'hABCD;
    bus.rf_stall  = 1'b0;
    #1;
    total++; if (bus.rf_we !== 1'b1) begin bad++; $display("[TB] FAIL cp0_rf_we: got %0b expected 1", bus.rf_we); end
    total++; if (bus.rf_wdata !== 32'hABCD) begin bad++; $display("[TB] FAIL cp0_rf_wdata: got %h expected 0000abcd", bus.rf_wdata); end
    total++; if (bus.debug_wb_rf_wnum !== 5'd9) begin bad++; $display("[TB] FAIL cp0_dbg_wnum: got %0d expected 9", bus.debug_wb_rf_wnum); end
    step();
    set_ms(1'b1, 5'd4, 32'h0, 1'b0);
    bus.ms_mtc0_we  = 1'b1;
    bus.ms_rt_value = 32'h55;
    bus.ms_cp0_addr = 5'd12;
    step();
    set_ms(1'b0, 5'd0, 32'h0, 1'b0);
    #1;
    total++; if (bus.mtc0_we !== 1'b1) begin bad++; $display("[TB] FAIL mtc0_we: got %0b expected 1", bus.mtc0_we); end
    total++; if (bus.cp0_wdata !== 32'h55) begin bad++; $display("[TB] FAIL mtc0_wdata: got %h expected 00000055", bus.cp0_wdata); end
    total++; if (bus.rf_we !== 1'b0) begin bad++; $display("[TB] FAIL mtc0_rf_we: got %0b expected 0", bus.rf_we); end
    step();
    #1;
    total++; if (bus.cp0_wdata !== 32'h0) begin bad++; $display("[TB] FAIL mtc0_idle_wdata: got %h expected 00000000", bus.cp0_wdata); end
  endtask

  task automatic test_reset_midrun();
    bus.rf_stall = 1'b1;
    set_ms(1'b1, 5'd1, 32'h31, 1'b1);
    step();
    set_ms(1'b1, 5'd2, 32'h32, 1'b1);
    step();
    set_ms(1'b0, 5'd0, 32'h0, 1'b0);
    #1;
    total++; if (bus.ws_count !== 2'd2) begin bad++; $display("[TB] FAIL rst_mid_pre: got %0d expected 2", bus.ws_count); end
    resetn = 1'b0;
    step();
    #1;
    total++; if (bus.ws_count !== 2'd0) begin bad++; $display("[TB] FAIL rst_mid_count: got %0d expected 0", bus.ws_count); end
    total++; if (bus.ws_allowin !== 1'b1) begin bad++; $display("[TB] FAIL rst_mid_allowin: got %0b expected 1", bus.ws_allowin); end
    bus.rf_stall = 1'b0;
    resetn = 1'b1;
    #1;
    total++; if (bus.rf_we !== 1'b0) begin bad++; $display("[TB] FAIL rst_mid_rf_we: got %0b expected 0", bus.rf_we); end
    step();
    #1;
    total++; if (bus.ws_count !== 2'd0) begin bad++; $display("[TB] FAIL rst_mid_after: got %0d expected 0", bus.ws_count); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    $display("[TB] starting wb_stage_buf bench");
    test_reset();
    test_basic_commit();
    test_full_stall();
    test_bypass();
    test_exception_flush();
    test_eret();
    test_cp0();
    test_reset_midrun();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
